// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the hazard unit.
//   REG_AW   : architectural register index width
//   REG_ZERO : hard-wired zero register, never a hazard source
//   trk_entry_t : one in-flight load record {valid, rd}
package cpu_pkg;

   localparam int REG_AW = 5;

   localparam logic [REG_AW-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
   } trk_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Handshake bundle between the ID/EX pipeline control and hazard_scoreboard.
//   master : pipeline side, drives ID/EX status, receives stall/flush controls
//   slave  : hazard_scoreboard side
// Ports carried: id_rs, id_rt, id_use_rs, id_use_rt, ex_valid, ex_mem_read,
// ex_rd, ex_branch_taken (to slave); pc_write, ifid_write, idex_bubble,
// ifid_flush, stall_cnt, flush_cnt (from slave).
interface hazard_scoreboard_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_use_rs;
   logic              id_use_rt;
   logic              ex_valid;
   logic              ex_mem_read;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_branch_taken;
   logic              pc_write;
   logic              ifid_write;
   logic              idex_bubble;
   logic              ifid_flush;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt,
             ex_valid, ex_mem_read, ex_rd, ex_branch_taken,
      input  pc_write, ifid_write, idex_bubble, ifid_flush,
             stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt,
             ex_valid, ex_mem_read, ex_rd, ex_branch_taken,
      output pc_write, ifid_write, idex_bubble, ifid_flush,
             stall_cnt, flush_cnt
   );
endinterface

// File: rtl/load_tracker.sv
// In-flight load tracker: LOAD_LAT-1 deep shift register of {valid, rd}
// records for loads that have left EX but whose data is not yet forwardable.
// Shifts every cycle (back end never stalls). Reports a hit when any valid
// entry matches a source register the ID instruction actually reads.
// For LOAD_LAT=1 there are no entries and hit is constant 0.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (clears entries)
//   ld_valid, ld_rd   : qualified EX load (already excludes rd == 0)
//   id_rs, id_rt      : ID source registers
//   id_use_rs/rt      : ID source register read enables
//   hit               : some in-flight load feeds the ID instruction
module load_tracker
   import cpu_pkg::*;
#(
   parameter int LOAD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_valid,
   input  logic [REG_AW-1:0] ld_rd,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   output logic              hit
);

   if (LOAD_LAT > 1) begin : g_trk
      localparam int DEPTH = LOAD_LAT - 1;

      trk_entry_t       ent [DEPTH];
      logic [DEPTH-1:0] ent_hit;

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int k = 0; k < DEPTH; k++) ent[k] <= '0;
         end else begin
            ent[0] <= '{valid: ld_valid, rd: ld_rd};
            for (int k = 1; k < DEPTH; k++) ent[k] <= ent[k-1];
         end
      end

      always_comb begin
         ent_hit = '0;
         for (int k = 0; k < DEPTH; k++) begin
            ent_hit[k] = ent[k].valid &&
                         ((id_use_rs && (id_rs == ent[k].rd)) ||
                          (id_use_rt && (id_rt == ent[k].rd)));
         end
      end

      assign hit = |ent_hit;
   end else begin : g_none
      logic unused_trk;
      assign unused_trk = ^{clk, rst, ld_valid, ld_rd, id_rs, id_rt,
                            id_use_rs, id_use_rt};
      assign hit = 1'b0;
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard and control-flush unit for the 5-stage pipeline.
// Stalls IF/ID and injects an ID/EX bubble while the ID instruction depends on
// a load in EX or still in flight (LOAD_LAT cycles total); a taken branch in
// EX flushes IF/ID and bubbles ID/EX, overriding any stall.
// Optional statistics: define HAZARD_STATS_EN to build the saturating stall and
// flush counters; otherwise stall_cnt/flush_cnt are tied to 0.
// Parameters: REG_AW (register index width), LOAD_LAT (1..4), CNT_W.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   hz       : hazard_scoreboard_if slave (ID/EX status in, controls/stats out)
module hazard_scoreboard
   import cpu_pkg::*;
#(
   parameter int REG_AW   = cpu_pkg::REG_AW,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   hazard_scoreboard_if.slave  hz
);

   logic ex_ld_q;
   logic ex_hit;
   logic trk_hit;
   logic stall;

   // rd == 0 loads are dropped here so the tracker never holds register 0.
   assign ex_ld_q = hz.ex_valid && hz.ex_mem_read && (hz.ex_rd != REG_ZERO);

   assign ex_hit = ex_ld_q &&
                   ((hz.id_use_rs && (hz.id_rs == hz.ex_rd)) ||
                    (hz.id_use_rt && (hz.id_rt == hz.ex_rd)));

   load_tracker #(
      .LOAD_LAT (LOAD_LAT)
   ) u_trk (
      .clk       (clk),
      .rst       (rst),
      .ld_valid  (ex_ld_q),
      .ld_rd     (hz.ex_rd),
      .id_rs     (hz.id_rs),
      .id_rt     (hz.id_rt),
      .id_use_rs (hz.id_use_rs),
      .id_use_rt (hz.id_use_rt),
      .hit       (trk_hit)
   );

   // A taken branch discards the ID instruction, so its hazard is moot.
   assign stall = (ex_hit || trk_hit) && !hz.ex_branch_taken;

   always_comb begin
      hz.pc_write    = 1'b1;
      hz.ifid_write  = 1'b1;
      hz.idex_bubble = 1'b0;
      hz.ifid_flush  = 1'b0;
      if (!rst) begin
         if (hz.ex_branch_taken) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
         end else if (stall) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_bubble = 1'b1;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 1'b1;
         if (hz.ex_branch_taken && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;
`else
   assign hz.stall_cnt = '0;
   assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: four instances (LOAD_LAT 1/2/3 with 16-bit
// counters, LOAD_LAT 1 with 2-bit counters) share one stimulus stream.
module tb_hazard_scoreboard;

`ifdef HAZARD_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      bit       rst;
      bit [4:0] rs;
      bit [4:0] rt;
      bit       urs;
      bit       urt;
      bit       exv;
      bit       mr;
      bit [4:0] rd;
      bit       br;
      bit [2:0] st;   // expected stall for LOAD_LAT 3,2,1 (bit2..bit0)
      bit       fl;   // expected flush
   } vec_t;

   typedef struct {
      bit       rst;
      bit [2:0] st;
      bit       fl;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] rs = '0, rt = '0, rd = '0;
   logic       urs = 1'b0, urt = 1'b0, exv = 1'b0, mr = 1'b0, br = 1'b0;

   int checks = 0;
   int errors = 0;
   exp_t q[$];
   vec_t tbl[$];
   int sc[4];
   int fc[4];
   int cmax[4] = '{65535, 65535, 65535, 3};

   always #5 clk = ~clk;

   hazard_scoreboard_if #(.REG_AW(5), .CNT_W(16)) hz1 ();
   hazard_scoreboard_if #(.REG_AW(5), .CNT_W(16)) hz2 ();
   hazard_scoreboard_if #(.REG_AW(5), .CNT_W(16)) hz3 ();
   hazard_scoreboard_if #(.REG_AW(5), .CNT_W(2))  hzs ();

   assign {hz1.id_rs, hz1.id_rt, hz1.id_use_rs, hz1.id_use_rt, hz1.ex_valid, hz1.ex_mem_read, hz1.ex_rd, hz1.ex_branch_taken} = {rs, rt, urs, urt, exv, mr, rd, br};
   assign {hz2.id_rs, hz2.id_rt, hz2.id_use_rs, hz2.id_use_rt, hz2.ex_valid, hz2.ex_mem_read, hz2.ex_rd, hz2.ex_branch_taken} = {rs, rt, urs, urt, exv, mr, rd, br};
   assign {hz3.id_rs, hz3.id_rt, hz3.id_use_rs, hz3.id_use_rt, hz3.ex_valid, hz3.ex_mem_read, hz3.ex_rd, hz3.ex_branch_taken} = {rs, rt, urs, urt, exv, mr, rd, br};
   assign {hzs.id_rs, hzs.id_rt, hzs.id_use_rs, hzs.id_use_rt, hzs.ex_valid, hzs.ex_mem_read, hzs.ex_rd, hzs.ex_branch_taken} = {rs, rt, urs, urt, exv, mr, rd, br};

   hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .hz(hz1));
   hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(16)) u2 (.clk(clk), .rst(rst), .hz(hz2));
   hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u3 (.clk(clk), .rst(rst), .hz(hz3));
   hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(2))  us (.clk(clk), .rst(rst), .hz(hzs));

   function automatic vec_t mk(bit r, int a, int b, bit ua, bit ub, bit v, bit m,
                               int d, bit bt, bit [2:0] s, bit f);
      vec_t x;
      x.rst = r; x.rs = a[4:0]; x.rt = b[4:0]; x.urs = ua; x.urt = ub;
      x.exv = v; x.mr = m; x.rd = d[4:0]; x.br = bt; x.st = s; x.fl = f;
      return x;
   endfunction

   // {pc_write, ifid_write, idex_bubble, ifid_flush}
   function automatic logic [3:0] outs(int d);
      case (d)
         0:       return {hz1.pc_write, hz1.ifid_write, hz1.idex_bubble, hz1.ifid_flush};
         1:       return {hz2.pc_write, hz2.ifid_write, hz2.idex_bubble, hz2.ifid_flush};
         2:       return {hz3.pc_write, hz3.ifid_write, hz3.idex_bubble, hz3.ifid_flush};
         default: return {hzs.pc_write, hzs.ifid_write, hzs.idex_bubble, hzs.ifid_flush};
      endcase
   endfunction

   function automatic int scnt(int d);
      case (d)
         0:       return int'(hz1.stall_cnt);
         1:       return int'(hz2.stall_cnt);
         2:       return int'(hz3.stall_cnt);
         default: return int'(hzs.stall_cnt);
      endcase
   endfunction

   function automatic int fcnt(int d);
      case (d)
         0:       return int'(hz1.flush_cnt);
         1:       return int'(hz2.flush_cnt);
         2:       return int'(hz3.flush_cnt);
         default: return int'(hzs.flush_cnt);
      endcase
   endfunction

   function automatic logic [3:0] exp_outs(bit r, bit s, bit f);
      if (r)      return 4'b1100;
      else if (f) return 4'b1111;
      else if (s) return 4'b0010;
      else        return 4'b1100;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      bit   s;
      @(negedge clk);
      rst = v.rst; rs = v.rs; rt = v.rt; urs = v.urs; urt = v.urt;
      exv = v.exv; mr = v.mr; rd = v.rd; br = v.br;
      e.rst = v.rst; e.st = v.st; e.fl = v.fl;
      q.push_back(e);
      #1;
      e = q.pop_front();
      for (int d = 0; d < 4; d++) begin
         s = (d == 3) ? e.st[0] : e.st[d];
         chk($sformatf("%s dut%0d ctl{pcw,ifw,bub,fl}", tag, d), int'(outs(d)),
             int'(exp_outs(e.rst, s, e.fl)));
         chk($sformatf("%s dut%0d stall_cnt", tag, d), scnt(d), STATS ? sc[d] : 0);
         chk($sformatf("%s dut%0d flush_cnt", tag, d), fcnt(d), STATS ? fc[d] : 0);
      end
      @(posedge clk);
      for (int d = 0; d < 4; d++) begin
         s = (d == 3) ? e.st[0] : e.st[d];
         if (e.rst) begin
            sc[d] = 0; fc[d] = 0;
         end else begin
            if (s && sc[d] < cmax[d])    sc[d] = sc[d] + 1;
            if (e.fl && fc[d] < cmax[d]) fc[d] = fc[d] + 1;
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 4; d++) begin sc[d] = 0; fc[d] = 0; end
      repeat (2) @(posedge clk);

      //           rst rs rt urs urt exv mr rd br  st      fl
      tbl.push_back(mk(1, 5, 0, 1, 0, 1, 1, 5, 0, 3'b000, 0)); // reset forces idle controls
      tbl.push_back(mk(0, 5, 0, 1, 0, 1, 1, 5, 0, 3'b111, 0)); // load rd5, ID rs5
      tbl.push_back(mk(0, 5, 0, 1, 0, 0, 0, 0, 0, 3'b110, 0));
      tbl.push_back(mk(0, 5, 0, 1, 0, 0, 0, 0, 0, 3'b100, 0));
      tbl.push_back(mk(0, 5, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0, 3'b000, 0)); // rd0 never hazards
      tbl.push_back(mk(0, 9, 3, 0, 1, 1, 1, 9, 0, 3'b000, 0)); // rs9 not used
      tbl.push_back(mk(0, 9, 9, 0, 0, 0, 0, 0, 0, 3'b000, 0));
      tbl.push_back(mk(0, 4, 0, 1, 0, 1, 1, 4, 1, 3'b000, 1)); // branch beats stall
      tbl.push_back(mk(0, 4, 0, 1, 0, 0, 0, 0, 0, 3'b110, 0)); // tracker kept through flush
      tbl.push_back(mk(0, 0, 4, 0, 1, 0, 0, 0, 0, 3'b100, 0));
      tbl.push_back(mk(0, 7, 7, 0, 1, 1, 1, 7, 0, 3'b111, 0)); // load rd7, ID rt7
      tbl.push_back(mk(0, 0, 7, 0, 1, 1, 0, 7, 0, 3'b110, 0)); // ALU op rd7 in EX
      tbl.push_back(mk(0, 0, 7, 0, 1, 1, 1, 7, 1, 3'b000, 1)); // load under branch
      tbl.push_back(mk(0, 0, 7, 0, 1, 0, 0, 0, 0, 3'b110, 0));
      tbl.push_back(mk(0, 0, 7, 0, 1, 0, 0, 0, 0, 3'b100, 0));
      tbl.push_back(mk(0, 0, 7, 0, 1, 0, 0, 0, 0, 3'b000, 0));

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

      // Reset mid-stall: tracker history must be discarded.
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0), "rst0");
      apply(mk(0, 6, 0, 1, 0, 1, 1, 6, 0, 3'b111, 0), "rst1");
      apply(mk(1, 6, 0, 1, 0, 1, 1, 6, 0, 3'b000, 0), "rst2");
      apply(mk(0, 6, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0), "rst3");

      // Five stall cycles: 2-bit counter saturates at 3, 16-bit reaches 5.
      for (int i = 0; i < 5; i++)
         apply(mk(0, 5, 0, 1, 0, 1, 1, 5, 0, 3'b111, 0), $sformatf("sat%0d", i));
      apply(mk(0, 5, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0), "sat5");
      chk("sat stall_cnt model lat1", sc[0], 5);
      chk("sat stall_cnt model cw2", sc[3], 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
